// File: rtl/tff_sr.sv
// tff_sr: vector of independent T flip-flops; clk, reset (sync, active-high), data (toggle per bit), q (state), q_n (~q)
module tff_sr #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk)
    r_q <= reset ? RESET_VAL : r_q ^ data;
  assign q   = r_q;
  assign q_n = ~r_q;
endmodule

// File: tb/tb_tff_sr.sv
// tb_tff_sr: randomized scoreboard bench for a 1-bit and a 4-bit (RESET_VAL=1010) tff_sr
module tb_tff_sr;
  logic       clk = 1'b0;
  logic       reset;
  logic       d1;
  logic [3:0] d4;
  logic       q1, qn1;
  logic [3:0] q4, qn4;
  typedef struct packed {
    logic       e1;
    logic [3:0] e4;
  } exp_t;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       m1;
  logic [3:0] m4;
  localparam logic [3:0] RV4 = 4'b1010;

  tff_sr u_dut1 (.clk(clk), .reset(reset), .data(d1), .q(q1), .q_n(qn1));
  tff_sr #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (.clk(clk), .reset(reset), .data(d4), .q(q4), .q_n(qn4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, req, $time);
    end
  endtask

  // reference: each edge, reset loads the reset value, otherwise every requested bit flips
  task automatic step(input logic r, input logic a, input logic [3:0] b);
    reset = r;
    d1 = a;
    d4 = b;
    if (r) begin
      m1 = 1'b0;
      m4 = RV4;
    end else begin
      if (a) m1 = !m1;
      for (int i = 0; i < 4; i++) if (b[i]) m4[i] = !m4[i];
    end
    sb.push_back('{e1: m1, e4: m4});
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q1",  {3'b000, q1},  {3'b000, e.e1});
      chk("qn1", {3'b000, qn1}, {3'b000, !e.e1});
      chk("q4",  q4,  e.e4);
      chk("qn4", qn4, ~e.e4);
    end
  end

  initial begin
    m1 = 1'bx;
    m4 = 4'bxxxx;
    step(1'b1, 1'b0, 4'h0);
    repeat (3) step(1'b0, 1'b0, 4'h0);
    repeat (4) step(1'b0, 1'b1, 4'hf);
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hf);
    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hf);
    step(1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h3);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    // reset pulse between edges must be ignored
    d1 = 1'b0;
    d4 = 4'h0;
    reset = 1'b1;
    #2 reset = 1'b0;
    step(1'b0, 1'b1, 4'h6);
    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom));
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
